// File: rtl/store_merge_if.sv
// ---------------------------------------------------------------------------
// store_merge_if
//   Bundles the request handshake and the word-only memory port of the
//   sub-word store unit.
//
//   Request side : req_valid, req_ready, req_addr, req_data, req_size
//   Memory side  : mem_addr, mem_rd, mem_wr, mem_wdata, mem_rdata, mem_ack
//   Status       : done, err (one-cycle pulses)
//
//   slave  : the store unit itself
//   master : whatever drives requests and answers the memory port
// ---------------------------------------------------------------------------
interface store_merge_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic [29:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        done;
    logic        err;

    modport slave (
        input  req_valid, req_addr, req_data, req_size, mem_rdata, mem_ack,
        output req_ready, mem_addr, mem_rd, mem_wr, mem_wdata, done, err
    );

    modport master (
        output req_valid, req_addr, req_data, req_size, mem_rdata, mem_ack,
        input  req_ready, mem_addr, mem_rd, mem_wr, mem_wdata, done, err
    );
endinterface

// File: rtl/store_merge.sv
// ---------------------------------------------------------------------------
// store_merge
//   Sub-word store unit between the CPU memory stage and a word-only data
//   memory. Byte and halfword stores are done as read-modify-write (read the
//   word, replace one lane, write it back); word stores are a single write.
//   Misaligned or illegal-size requests are rejected with an err pulse and
//   never touch memory.
//
//   Parameters
//     LITTLE_ENDIAN : 1 -> byte k at bits [8k+7:8k]
//                     0 -> byte k at bits [31-8k:24-8k]
//   Ports
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     bus   : store_merge_if.slave (request, memory port, done/err)
// ---------------------------------------------------------------------------
module store_merge #(
    parameter bit LITTLE_ENDIAN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    store_merge_if.slave bus
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q,  addr_d;
    logic [15:0] data_q,  data_d;    // only the low half ever reaches a sub-word lane
    logic [1:0]  size_q,  size_d;
    logic [31:0] wdata_q, wdata_d;

    logic        req_bad;
    logic [31:0] merged;

    // Rejection rules: illegal size, odd halfword, or word not 4-byte aligned.
    always_comb begin
        req_bad = 1'b0;
        if (bus.req_size == SZ_ILL)
            req_bad = 1'b1;
        else if (bus.req_size == SZ_HALF && bus.req_addr[0])
            req_bad = 1'b1;
        else if (bus.req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00)
            req_bad = 1'b1;
    end

    // -----------------------------------------------------------------------
    // Lane merge. Each physical byte lane gi decides on its own whether it is
    // overwritten. LANE_POS is the byte address offset that lands in this
    // physical lane for the configured endianness. A halfword always occupies
    // an aligned 16-bit physical field, so its upper data byte goes to the odd
    // physical lane in both byte orders.
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE_POS = LITTLE_ENDIAN ? 2'(gi) : 2'(3 - gi);

            logic       lane_hit;
            logic [7:0] lane_byte;

            always_comb begin
                lane_hit = 1'b0;
                if (size_q == SZ_BYTE && addr_q[1:0] == LANE_POS)
                    lane_hit = 1'b1;
                else if (size_q == SZ_HALF && addr_q[1] == LANE_POS[1])
                    lane_hit = 1'b1;
            end

            if (gi % 2 == 1) begin : g_odd
                assign lane_byte = (size_q == SZ_HALF) ? data_q[15:8] : data_q[7:0];
            end else begin : g_even
                assign lane_byte = data_q[7:0];
            end

            assign merged[8*gi +: 8] = lane_hit ? lane_byte : bus.mem_rdata[8*gi +: 8];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // State register and datapath registers. The reset is asynchronous so the
    // memory strobes, which are decoded from state_q, drop immediately.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state and outputs. mem_addr and mem_wdata come straight from
    // registers that only change on accept or on the read ack, so both are
    // stable for the whole of any strobe.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        data_d        = data_q;
        size_d        = size_q;
        wdata_d       = wdata_q;
        bus.req_ready = 1'b0;
        bus.mem_rd    = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.done      = 1'b0;
        bus.err       = 1'b0;
        bus.mem_addr  = addr_q[31:2];
        bus.mem_wdata = wdata_q;

        case (state_q)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    addr_d = bus.req_addr;
                    data_d = bus.req_data[15:0];
                    size_d = bus.req_size;
                    if (req_bad) begin
                        state_d = ST_ERR;
                    end else if (bus.req_size == SZ_WORD) begin
                        wdata_d = bus.req_data;
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end

            ST_READ: begin
                bus.mem_rd = 1'b1;
                if (bus.mem_ack) begin
                    wdata_d = merged;
                    state_d = ST_WRITE;
                end
            end

            ST_WRITE: begin
                bus.mem_wr = 1'b1;
                if (bus.mem_ack)
                    state_d = ST_DONE;
            end

            ST_DONE: begin
                bus.done = 1'b1;
                state_d  = ST_IDLE;
            end

            ST_ERR: begin
                bus.err = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_store_merge.sv
// ---------------------------------------------------------------------------
// tb_store_merge
//   Drives a little-endian and a big-endian store_merge in lockstep from the
//   same request and memory-response signals. A word-addressed memory model
//   answers the strobes with a programmable number of wait cycles; expected
//   write words are computed by shift/mask arithmetic from the store rules.
// ---------------------------------------------------------------------------
module tb_store_merge;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    initial forever #5 clk = ~clk;

    store_merge_if bus_le ();
    store_merge_if bus_be ();

    store_merge #(.LITTLE_ENDIAN(1'b1)) dut_le (.clk(clk), .rst_n(rst_n), .bus(bus_le));
    store_merge #(.LITTLE_ENDIAN(1'b0)) dut_be (.clk(clk), .rst_n(rst_n), .bus(bus_be));

    assign bus_be.req_valid = bus_le.req_valid;
    assign bus_be.req_addr  = bus_le.req_addr;
    assign bus_be.req_data  = bus_le.req_data;
    assign bus_be.req_size  = bus_le.req_size;
    assign bus_be.mem_rdata = bus_le.mem_rdata;
    assign bus_be.mem_ack   = bus_le.mem_ack;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- memory model ----------------
    logic [31:0] mem [int unsigned];

    function automatic logic [31:0] mem_read(input logic [29:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return {2'b10, a} ^ 32'h3C5A_96E1;
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] old, input logic [31:0] addr,
                                                input logic [31:0] data, input logic [1:0] size,
                                                input bit le);
        int          shift;
        logic [31:0] mask;
        logic [31:0] val;
        if (size == 2'b10) return data;
        if (size == 2'b00) begin
            shift = le ? 8 * int'(addr[1:0]) : 24 - 8 * int'(addr[1:0]);
            mask  = 32'h0000_00FF;
        end else begin
            shift = le ? 16 * int'(addr[1]) : 16 - 16 * int'(addr[1]);
            mask  = 32'h0000_FFFF;
        end
        val = data & mask;
        return (old & ~(mask << shift)) | (val << shift);
    endfunction

    // ---------------- memory responder / monitor ----------------
    int          rd_wait = 0, wr_wait = 0;
    int          rd_total = 0, wr_total = 0;
    int          done_total = 0, err_total = 0;
    int          stab_viol = 0, strobe_viol = 0;
    logic [29:0] last_rd_addr = '0, last_wr_addr = '0;
    logic [31:0] last_wr_le = '0, last_wr_be = '0;

    initial begin : responder
        int          cyc;
        logic [1:0]  kind, prev_kind;
        logic [29:0] a0;
        logic [31:0] d0, d0b;
        bus_le.mem_ack   = 1'b0;
        bus_le.mem_rdata = '0;
        prev_kind = 2'b00;
        cyc = 0;
        a0 = '0; d0 = '0; d0b = '0;
        forever begin
            @(negedge clk);
            if (bus_le.done) done_total++;
            if (bus_le.err)  err_total++;
            kind = {bus_le.mem_wr, bus_le.mem_rd};
            if (kind == 2'b11) strobe_viol++;
            if (bus_be.mem_rd !== bus_le.mem_rd || bus_be.mem_wr !== bus_le.mem_wr) strobe_viol++;
            if (kind == 2'b00) begin
                cyc = 0;
                bus_le.mem_ack = 1'b0;
            end else begin
                if (kind != prev_kind) begin
                    cyc = 0;
                    a0  = bus_le.mem_addr;
                    d0  = bus_le.mem_wdata;
                    d0b = bus_be.mem_wdata;
                end else if (a0 !== bus_le.mem_addr || d0 !== bus_le.mem_wdata ||
                             d0b !== bus_be.mem_wdata) begin
                    stab_viol++;
                end
                cyc++;
                if (cyc > ((kind == 2'b01) ? rd_wait : wr_wait)) begin
                    bus_le.mem_ack = 1'b1;
                    if (kind == 2'b01) begin
                        bus_le.mem_rdata = mem_read(bus_le.mem_addr);
                        last_rd_addr = bus_le.mem_addr;
                        rd_total++;
                    end else begin
                        mem[int'(bus_le.mem_addr)] = bus_le.mem_wdata;
                        last_wr_addr = bus_le.mem_addr;
                        last_wr_le   = bus_le.mem_wdata;
                        last_wr_be   = bus_be.mem_wdata;
                        wr_total++;
                    end
                end else begin
                    bus_le.mem_ack = 1'b0;
                end
            end
            prev_kind = kind;
        end
    end

    int exp_done = 0, exp_err = 0;

    // One store transaction; entered and left 1 time unit after a rising edge.
    task automatic do_store(input logic [31:0] addr, input logic [31:0] data,
                            input logic [1:0] size, input int rw, input int ww);
        int          rd0, wr0, lat, exp_lat;
        bit          bad;
        logic [29:0] wa;
        logic [31:0] old, exp_le, exp_be;
        wa  = addr[31:2];
        bad = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
        old = mem_read(wa);
        exp_le = model_merge(old, addr, data, size, 1'b1);
        exp_be = model_merge(old, addr, data, size, 1'b0);
        rd_wait = rw;
        wr_wait = ww;
        rd0 = rd_total;
        wr0 = wr_total;

        check("ready_before", {31'b0, bus_le.req_ready}, 32'd1);
        bus_le.req_valid = 1'b1;
        bus_le.req_addr  = addr;
        bus_le.req_data  = data;
        bus_le.req_size  = size;
        @(posedge clk);
        #1;
        bus_le.req_valid = 1'b0;
        bus_le.req_addr  = $urandom;
        bus_le.req_data  = $urandom;
        bus_le.req_size  = 2'($urandom_range(0, 3));

        lat = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (bus_le.done || bus_le.err) begin
                lat = c;
                break;
            end
        end
        exp_lat = bad ? 1 : ((size == 2'b10) ? 2 + ww : 3 + rw + ww);
        check("latency", lat, exp_lat);
        check("pulse_kind", {30'b0, bus_le.done, bus_le.err}, bad ? 32'd1 : 32'd2);
        if (bad) exp_err++; else exp_done++;

        @(negedge clk);
        check("ready_after", {31'b0, bus_le.req_ready}, 32'd1);
        check("pulse_single", {30'b0, bus_le.done, bus_le.err}, 32'd0);
        check("rd_count", rd_total - rd0, (bad || size == 2'b10) ? 0 : 1);
        check("wr_count", wr_total - wr0, bad ? 0 : 1);
        if (!bad) begin
            check("wr_addr", {2'b0, last_wr_addr}, {2'b0, wa});
            check("wdata_le", last_wr_le, exp_le);
            check("wdata_be", last_wr_be, exp_be);
            if (size != 2'b10) check("rd_addr", {2'b0, last_rd_addr}, {2'b0, wa});
        end
        $display("store addr=0x%08h data=0x%08h size=%0d waits=%0d/%0d lat=%0d le=0x%08h be=0x%08h bad=%0d",
                 addr, data, size, rw, ww, lat, last_wr_le, last_wr_be, bad);
        @(posedge clk);
        #1;
    endtask

    initial begin : stimulus
        int wr_snap, done_snap, err_snap;
        bus_le.req_valid = 1'b0;
        bus_le.req_addr  = '0;
        bus_le.req_data  = '0;
        bus_le.req_size  = '0;

        // Reset state before any clock edge.
        #2;
        check("rst_ready", {31'b0, bus_le.req_ready}, 32'd1);
        check("rst_rd",    {31'b0, bus_le.mem_rd},    32'd0);
        check("rst_wr",    {31'b0, bus_le.mem_wr},    32'd0);
        check("rst_addr",  {2'b0, bus_le.mem_addr},   32'd0);
        check("rst_wdata", bus_le.mem_wdata,          32'd0);
        check("rst_done",  {31'b0, bus_le.done},      32'd0);
        check("rst_err",   {31'b0, bus_le.err},       32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases.
        mem[32'h40] = 32'h1122_3344;
        do_store(32'h0000_0102, 32'hFFFF_FFAB, 2'b00, 0, 0);
        check("byte_plan", last_wr_le, 32'h11AB_3344);
        mem[32'h80] = 32'hDEAD_C0DE;
        do_store(32'h0000_0202, 32'h1234_BEEF, 2'b01, 0, 0);
        check("half_plan_le", last_wr_le, 32'hBEEF_C0DE);
        check("half_plan_be", last_wr_be, 32'hDEAD_BEEF);
        do_store(32'h0000_0300, 32'hCAFE_F00D, 2'b10, 0, 0);
        check("word_plan", last_wr_le, 32'hCAFE_F00D);
        do_store(32'h0000_0201, 32'h0000_1234, 2'b01, 0, 0);
        do_store(32'h0000_0302, 32'h5555_AAAA, 2'b10, 0, 0);
        do_store(32'h0000_0400, 32'h0000_0001, 2'b11, 0, 0);
        do_store(32'h0000_0103, 32'h0000_0077, 2'b00, 3, 3);
        do_store(32'h0000_0300, 32'h0BAD_F00D, 2'b10, 0, 3);

        // Reset while the read strobe is outstanding.
        rd_wait = 20;
        wr_snap   = wr_total;
        done_snap = done_total;
        err_snap  = err_total;
        bus_le.req_valid = 1'b1;
        bus_le.req_addr  = 32'h0000_0501;
        bus_le.req_data  = 32'h0000_00EE;
        bus_le.req_size  = 2'b00;
        @(posedge clk);
        #1;
        bus_le.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midread_rd", {31'b0, bus_le.mem_rd}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rd_drop", {31'b0, bus_le.mem_rd}, 32'd0);
        check("async_ready",   {31'b0, bus_le.req_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_no_write", wr_total - wr_snap, 0);
        check("rst_no_done",  done_total - done_snap, 0);
        check("rst_no_err",   err_total - err_snap, 0);
        check("rst_ready2",   {31'b0, bus_le.req_ready}, 32'd1);
        @(posedge clk);
        #1;
        do_store(32'h0000_0501, 32'h0000_00EE, 2'b00, 1, 0);

        // Randomized stores over a small window so words get revisited.
        for (int i = 0; i < 40; i++) begin
            do_store(32'h0000_1000 + 32'($urandom_range(0, 63)), $urandom,
                     2'($urandom_range(0, 3)), $urandom_range(0, 2), $urandom_range(0, 2));
        end

        check("done_total",  done_total, exp_done);
        check("err_total",   err_total, exp_err);
        check("stability",   stab_viol, 0);
        check("strobe_rule", strobe_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
